// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, presents it to a combinational ROM and buffers {pc, instr}
// in a small circular queue toward decode; redirects flush, bad addresses raise a sticky fault.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          DEPTH     = 2,
    parameter int          ROM_WORDS = 65536
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] instr_addr,
    input  logic [31:0] instr_data,
    input  logic        fetch_halt,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        fault,
    output logic [31:0] fault_pc
);

    localparam int              AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              CW        = AW + 1;
    localparam logic [CW-1:0]   DEPTH_C   = CW'(DEPTH);
    localparam logic [32:0]     ROM_BYTES = 33'(ROM_WORDS) * 33'd4;
    localparam logic [31:0]     NOP       = 32'h0000_0013;

    logic [31:0]   r_pc;
    logic [CW-1:0] r_count;
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic          r_fault;
    logic [31:0]   r_fault_pc;

    logic          w_valid;
    logic          w_pop;
    logic          w_push;
    logic          w_inrange;
    logic          w_redirect;
    logic          w_misaligned;
    logic          w_range_fault;
    logic [31:0]   w_ent_pc    [DEPTH];
    logic [31:0]   w_ent_instr [DEPTH];

    // All control terms are derived from pre-edge state; push uses the pre-pop count.
    assign w_valid       = (r_count != '0);
    assign w_pop         = w_valid & out_ready;
    assign w_inrange     = ({1'b0, r_pc} < ROM_BYTES);
    assign w_redirect    = redirect_valid & ~r_fault;
    assign w_misaligned  = (redirect_pc[1:0] != 2'b00);
    assign w_push        = ~redirect_valid & ~fetch_halt & ~r_fault & w_inrange
                           & (r_count < DEPTH_C);
    assign w_range_fault = ~w_inrange & ~r_fault & ~redirect_valid & ~fetch_halt;

    // Queue storage: each entry captures the fetched word when the tail points at it.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [31:0] r_ent_pc;
            logic [31:0] r_ent_instr;

            always_ff @(posedge clk) begin
                if (w_push && (r_wr_ptr == AW'(gi))) begin
                    r_ent_pc    <= r_pc;
                    r_ent_instr <= instr_data;
                end
            end

            assign w_ent_pc[gi]    = r_ent_pc;
            assign w_ent_instr[gi] = r_ent_instr;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc       <= RESET_PC;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_fault    <= 1'b0;
            r_fault_pc <= 32'h0;
        end else if (w_redirect) begin
            // A pop in this cycle is simply absorbed by the flush.
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            if (w_misaligned) begin
                r_fault    <= 1'b1;
                r_fault_pc <= redirect_pc;
            end else begin
                r_pc <= redirect_pc;
            end
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
                r_pc     <= r_pc + 32'd4;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            if (w_range_fault) begin
                r_fault    <= 1'b1;
                r_fault_pc <= r_pc;
            end
        end
    end

    assign instr_addr = r_pc;
    assign out_valid  = w_valid;
    assign out_instr  = w_valid ? w_ent_instr[r_rd_ptr] : NOP;
    assign out_pc     = w_valid ? w_ent_pc[r_rd_ptr]    : 32'h0;
    assign fault      = r_fault;
    assign fault_pc   = r_fault_pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit: a queue-level reference model predicts the
// delivered {pc, instr} stream and a negedge monitor checks every cycle against it.
module tb_instr_fetch_unit;

    localparam int          ROM_WORDS = 64;
    localparam int          DEPTH     = 2;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [32:0] ROM_BYTES = 33'(ROM_WORDS * 4);
    localparam logic [31:0] NOP       = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr_addr;
    logic [31:0] instr_data;
    logic        fetch_halt;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        fault;
    logic [31:0] fault_pc;

    int   n_checks = 0;
    int   n_errors = 0;
    bit   chk_en   = 1'b0;
    ent_t exp_q[$];

    logic [31:0] m_pc    = RESET_PC;
    int          m_count = 0;
    logic        m_fault = 1'b0;
    logic [31:0] m_fpc   = 32'h0;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .RESET_PC  (RESET_PC),
        .DEPTH     (DEPTH),
        .ROM_WORDS (ROM_WORDS)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .instr_addr     (instr_addr),
        .instr_data     (instr_data),
        .fetch_halt     (fetch_halt),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .fault          (fault),
        .fault_pc       (fault_pc)
    );

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        logic [31:0] t [4];
        t = '{32'h00b0_0093, 32'h1000_1137, 32'h0011_2023, 32'h0001_2183};
        if (a[31:4] == 28'h0) return t[a[3:2]];
        return (a * 32'h9E37_79B1) ^ 32'h5A00_0013;
    endfunction

    assign instr_data = rom_word(instr_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: advances once per rising edge from the inputs held over that cycle.
    always @(posedge clk) begin
        bit inr, pop, push;
        if (reset) begin
            m_pc    = RESET_PC;
            m_count = 0;
            m_fault = 1'b0;
            m_fpc   = 32'h0;
            exp_q.delete();
        end else begin
            inr = ({1'b0, m_pc} < ROM_BYTES);
            pop = (m_count > 0) && out_ready;
            if (!m_fault && redirect_valid) begin
                exp_q.delete();
                m_count = 0;
                if (redirect_pc[1:0] == 2'b00) begin
                    m_pc = redirect_pc;
                end else begin
                    m_fault = 1'b1;
                    m_fpc   = redirect_pc;
                end
            end else begin
                push = !redirect_valid && !fetch_halt && !m_fault && inr && (m_count < DEPTH);
                if (!inr && !m_fault && !redirect_valid && !fetch_halt) begin
                    m_fault = 1'b1;
                    m_fpc   = m_pc;
                end
                if (push) begin
                    exp_q.push_back('{pc: m_pc, instr: rom_word(m_pc)});
                    m_pc = m_pc + 32'd4;
                end
                m_count = m_count + int'(push) - int'(pop);
            end
        end
    end

    // Monitor: compares DUT outputs mid-cycle and retires the head on each accepted pop.
    always @(negedge clk) begin
        bit   exp_v;
        ent_t e;
        if (chk_en) begin
            exp_v = (exp_q.size() != 0);
            chk("instr_addr", instr_addr, m_pc);
            chk("fault", 32'(fault), 32'(m_fault));
            chk("fault_pc", fault_pc, m_fpc);
            chk("out_valid", 32'(out_valid), 32'(exp_v));
            if (out_valid && exp_v) begin
                if (out_ready) begin
                    e = exp_q.pop_front();
                    chk("out_pc", out_pc, e.pc);
                    chk("out_instr", out_instr, e.instr);
                    $display("pop pc=%h instr=%h", out_pc, out_instr);
                end
            end else if (!out_valid) begin
                chk("idle_pc", out_pc, 32'h0);
                chk("idle_instr", out_instr, NOP);
            end
        end
    end

    task automatic cyc(input bit r, input bit rdy, input bit h, input bit rv,
                       input logic [31:0] rp);
        reset          = r;
        out_ready      = rdy;
        fetch_halt     = h;
        redirect_valid = rv;
        redirect_pc    = rp;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit          r, rdy, h, rv;
        logic [31:0] rp;
        reset          = 1'b1;
        out_ready      = 1'b0;
        fetch_halt     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;

        // Streaming with decode always ready
        repeat (6) cyc(0, 1, 0, 0, 0);
        // Back-pressure from reset, then release
        cyc(1, 0, 0, 0, 0);
        repeat (4) cyc(0, 0, 0, 0, 0);
        repeat (4) cyc(0, 1, 0, 0, 0);
        // Redirect with a full queue
        repeat (3) cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 32'h40);
        repeat (4) cyc(0, 1, 0, 0, 0);
        // Misaligned redirect, ignored redirect, reset clears
        cyc(0, 1, 0, 1, 32'h42);
        repeat (3) cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 1, 32'h40);
        repeat (3) cyc(0, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        // Run off the end of the ROM
        cyc(0, 1, 0, 1, 32'hF0);
        repeat (8) cyc(0, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        // Reset pulse with a full queue, then restart
        repeat (3) cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        repeat (6) cyc(0, 1, 0, 0, 0);
        // Halt with pops, and redirect during halt
        cyc(0, 0, 1, 0, 0);
        cyc(0, 1, 1, 0, 0);
        cyc(0, 1, 1, 1, 32'h20);
        repeat (3) cyc(0, 1, 0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            r   = ($urandom_range(0, 199) == 0) || (m_fault && ($urandom_range(0, 15) == 0));
            rdy = ($urandom_range(0, 3) != 0);
            h   = ($urandom_range(0, 7) == 0);
            rv  = ($urandom_range(0, 15) == 0);
            rp  = {22'h0, 8'($urandom_range(0, 72)), 2'b00};
            if ($urandom_range(0, 7) == 0) rp[1:0] = 2'($urandom_range(1, 3));
            cyc(r, rdy, h, rv, rp);
        end

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
